io_bridge_fl: RTL
=================

Name: io_bridge_fl

Overview:
- Peripheral-side endpoint of the float core's IO port interface. The core drives req_in/addr_in and out_en/addr_out/data_out; this block answers them.
- Input side: per-port holding registers. External producers load them; the core reads them combinationally on io_in.
- Output side: core writes go into an {address,data} FIFO, which drains to external consumers through a valid/ready handshake.
- Sits between the processor core and user peripherals in the generated processor top.

Parameters:
- NBMANT, 16, mantissa bits; data word width W = NBMANT+NBEXPO+1.
- NBEXPO, 6, exponent bits.
- NUIOIN, 8, number of input ports (power of 2, at least 2); AIW = $clog2(NUIOIN).
- NUIOOU, 8, number of output ports (power of 2, at least 2); AOW = $clog2(NUIOOU).
- FDEPTH, 4, output FIFO entries (power of 2, at least 2); CW = $clog2(FDEPTH)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- io_in  out  W  data returned to the core for addr_in.
- addr_in  in  AIW  core input port address.
- req_in  in  1  core consumes input port addr_in this cycle.
- data_out  in  W  core output data.
- addr_out  in  AOW  core output port address.
- out_en  in  1  core writes data_out to addr_out this cycle.
- ext_in_wr  in  1  external write strobe into a holding register.
- ext_in_addr  in  AIW  external input port select.
- ext_in_data  in  W  external input data.
- ext_in_vld  out  NUIOIN  per-port "holding register full" flags.
- ext_out_valid  out  1  FIFO head entry is valid.
- ext_out_addr  out  AOW  head entry port address.
- ext_out_data  out  W  head entry data.
- ext_out_ready  in  1  consumer accepts the head entry.
- fifo_count  out  CW  FIFO occupancy, 0..FDEPTH.
- ovf  out  1  sticky flag: a core write was dropped.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async): all holding registers 0, ext_in_vld 0, FIFO pointers and count 0, ext_out_valid 0, ext_out_addr/data 0, ovf 0. Reset asserted mid-transfer discards all FIFO content and all holding data.
- io_in = hold[addr_in], purely combinational with zero latency, independent of req_in. An empty port returns its last held value (0 after reset).
- req_in at a rising edge: ext_in_vld[addr_in] <= 0 and the data is retained. req_in on an already-empty port has no effect.
- ext_in_wr at an edge: hold[ext_in_addr] <= ext_in_data and ext_in_vld[ext_in_addr] <= 1. A write to a full port overwrites (latest-value semantics) and causes no error.
- Same cycle, same address, ext_in_wr and req_in: the write wins. Data updates, vld ends at 1, and the core received the old value.
- Same cycle, different addresses: both actions take effect independently.
- Output FIFO:
  - push = out_en; pop = ext_out_valid & ext_out_ready.
  - Entry = {addr_out, data_out} captured at the edge.
  - ext_out_valid = (count != 0). ext_out_addr/data show the head entry combinationally from the storage array (first-word fall-through).
  - Latency: a push into an empty FIFO is visible on ext_out_valid one cycle later.
  - Pointers wrap modulo FDEPTH. count is updated +1 / -1 / unchanged.
  - Push while full and no pop: entry dropped, pointers unchanged, ovf <= 1.
  - Push and pop in the same cycle, full: both succeed and count stays FDEPTH.
  - Push and pop in the same cycle, empty: pop is ignored (valid=0) and push succeeds, so count becomes 1.
  - ext_out_ready while empty: no effect.
- ovf: set by a drop, cleared by ovf_clr. A drop and ovf_clr in the same cycle leave ovf = 1 (set wins).
- Out-of-range addresses cannot occur because the address widths match the port counts exactly.

Optional Feature:
- Macro IOB_DROP_CNT_EN.
- Defined: adds output port drop_cnt (8 bits). It increments by 1 on every dropped core write and saturates at 255. ovf_clr resets it to 0; a drop in the same cycle as ovf_clr gives 1. Reset value 0.
- Undefined: the port and counter are absent; ovf behaves as above.

Decomposition:
- Package iob_pkg holds:
  - width helpers: W, AIW, AOW, CW derivation functions;
  - FIFO entry layout constants: field offsets of addr and data within the {addr,data} word;
  - DROP_CNT_MAX = 255.
- Single sub-module iob_fifo: parameterised width/depth FWFT FIFO with push, pop, full, empty, count and a drop pulse. The top instantiates it with width AOW+W.
- Holding registers and vld flags stay in the top.

Test Plan:
- Reset, then addr_in=3 -> io_in=0, ext_in_vld=0, ext_out_valid=0, fifo_count=0, ovf=0.
- ext_in_wr port 5 data 0x12345; next cycle addr_in=5 -> io_in=0x12345 and vld[5]=1. req_in on port 5 -> vld[5]=0 next cycle and io_in still 0x12345.
- Same-cycle ext_in_wr port 2 data 0x00AAA with req_in port 2 (old data 0x00111) -> io_in showed 0x00111 that cycle; afterwards hold=0x00AAA, vld[2]=1.
- out_en four times, addr 1..4, data 0x10..0x13, ext_out_ready=0 -> fifo_count=4. Fifth out_en -> dropped and ovf=1. Then ready=1 -> entries emerge in order (1,0x10)..(4,0x13), one per cycle, and count reaches 0.
- With FIFO full, out_en and ext_out_ready in the same cycle -> count stays 4, no drop, ovf unchanged. Drop plus ovf_clr in the same cycle -> ovf stays 1.
- IOB_DROP_CNT_EN: 300 drops -> drop_cnt=255. Then ovf_clr -> drop_cnt=0. Then rst asserted mid-FIFO -> count=0 and ext_out_valid=0 immediately.

Source files
------------

// File: rtl/iob_pkg.sv
// iob_pkg: shared widths, FIFO entry layout and limits for the float-core IO bridge.
// Rev 1.0
`default_nettype none

package iob_pkg;

  localparam int DROP_CNT_W   = 8;
  localparam int DROP_CNT_MAX = 255;

  // FIFO entry is {addr, data}; data sits in the low bits.
  localparam int ENT_DATA_LSB = 0;

  function automatic int iob_word_w(input int nbmant, input int nbexpo);
    return nbmant + nbexpo + 1;
  endfunction

  function automatic int iob_addr_w(input int nports);
    return $clog2(nports);
  endfunction

  function automatic int iob_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int iob_ent_addr_lsb(input int word_w);
    return word_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_fifo.sv
// iob_fifo: first-word fall-through FIFO; a push into a full FIFO without a pop is dropped.
// Rev 1.0
`default_nettype none

module iob_fifo
  import iob_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = iob_count_w(DEPTH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A pop frees the slot this cycle, so a full FIFO still accepts a simultaneous push.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & o_full & ~w_pop;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/io_bridge_fl.sv
// io_bridge_fl: float-core IO endpoint - input holding registers and output {addr,data} FIFO.
// Optional IOB_DROP_CNT_EN adds a saturating drop_cnt output.  Rev 1.0
`default_nettype none

module io_bridge_fl
  import iob_pkg::*;
#(
  parameter int NBMANT = 16,
  parameter int NBEXPO = 6,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 4,
  localparam int W     = iob_word_w(NBMANT, NBEXPO),
  localparam int AIW   = iob_addr_w(NUIOIN),
  localparam int AOW   = iob_addr_w(NUIOOU),
  localparam int CW    = iob_count_w(FDEPTH),
  localparam int EW    = AOW + W
)(
  input  logic              clk,
  input  logic              rst,
  output logic [W-1:0]      io_in,
  input  logic [AIW-1:0]    addr_in,
  input  logic              req_in,
  input  logic [W-1:0]      data_out,
  input  logic [AOW-1:0]    addr_out,
  input  logic              out_en,
  input  logic              ext_in_wr,
  input  logic [AIW-1:0]    ext_in_addr,
  input  logic [W-1:0]      ext_in_data,
  output logic [NUIOIN-1:0] ext_in_vld,
  output logic              ext_out_valid,
  output logic [AOW-1:0]    ext_out_addr,
  output logic [W-1:0]      ext_out_data,
  input  logic              ext_out_ready,
  output logic [CW-1:0]     fifo_count,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef IOB_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic [W-1:0]      r_hold [NUIOIN];
  logic [NUIOIN-1:0] r_vld;
  logic              r_ovf;
  logic [EW-1:0]     w_head;
  logic              w_empty;
  logic              w_unused_full;
  logic              w_drop;

  assign io_in      = r_hold[addr_in];
  assign ext_in_vld = r_vld;
  assign ovf        = r_ovf;

  // Write is applied after the consume so a same-port collision leaves the port full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUIOIN; i++) r_hold[i] <= '0;
      r_vld <= '0;
    end else begin
      if (req_in) r_vld[addr_in] <= 1'b0;
      if (ext_in_wr) begin
        r_hold[ext_in_addr] <= ext_in_data;
        r_vld[ext_in_addr]  <= 1'b1;
      end
    end
  end

  iob_fifo #(
    .WIDTH (EW),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (out_en),
    .i_din   ({addr_out, data_out}),
    .i_pop   (ext_out_ready),
    .o_dout  (w_head),
    .o_full  (w_unused_full),
    .o_empty (w_empty),
    .o_count (fifo_count),
    .o_drop  (w_drop)
  );

  assign ext_out_valid = ~w_empty;
  assign ext_out_addr  = w_head[iob_ent_addr_lsb(W) +: AOW];
  assign ext_out_data  = w_head[ENT_DATA_LSB +: W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ovf <= 1'b0;
    else if (w_drop)   r_ovf <= 1'b1;
    else if (ovf_clr)  r_ovf <= 1'b0;
  end

`ifdef IOB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_drop_cnt <= '0;
    else if (ovf_clr)
      r_drop_cnt <= {{(DROP_CNT_W-1){1'b0}}, w_drop};
    else if (w_drop && r_drop_cnt != DROP_CNT_W'(DROP_CNT_MAX))
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
  end
`endif

endmodule

`default_nettype wire
